scan_chain_test_ctrl: RTL and testbench
=======================================

Name: scan_chain_test_ctrl

Overview:
Autonomous controller that sequences flush testing of one serial scan chain. It drives scan enable and scan-in, and samples scan-out. Each run applies three flush patterns:
- P0 all-ones: detects stuck-at-0.
- P1 all-zeros: detects stuck-at-1.
- P2 repeating 0011: detects hold and transition defects.

Each scan-out bit is compared to the bit shifted in CHAIN_LEN shifts earlier. The block reports per-pattern fail flags, a mismatch count and an inferred fault class. It sits between the test sequencer or register interface and a scan chain wrapper, including fault-injecting chain models.

Parameters:
- CHAIN_LEN, 8: number of flops in the chain, >= 2.
- GAP_CYCLES, 2: cycles with se low between patterns, >= 1.
- CNT_W, $clog2(3*CHAIN_LEN+1): width of err_count.

Ports:
- sclk  in  1  scan clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a run; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE next edge.
- so  in  1  chain scan-out, sampled on sclk rising edge.
- se  out  1  scan enable to chain, registered.
- si  out  1  scan-in to chain, registered.
- busy  out  1  high from the cycle after start is accepted until DONE is exited.
- done  out  1  one-cycle pulse at end of a completed run; not pulsed on abort.
- pass  out  1  high when fail_mask == 0; valid from done until the next start.
- fail_mask  out  3  bit k set if pattern Pk had at least one mismatch.
- err_count  out  CNT_W  total mismatches over the run; saturates at all-ones.
- fault_type  out  2  00 none, 01 SA0 (mask 001 or 101), 10 SA1 (mask 010 or 110), 11 other nonzero mask.

Behaviour:
- Reset: se=0, si=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, fault_type=0, state IDLE, counters 0. Reset overrides start and abort.
- States: IDLE -> SHIFT -> GAP -> SHIFT -> GAP -> SHIFT -> DONE -> IDLE. Pattern index pidx runs 0..2.
- IDLE:
  - On start: clear fail_mask, err_count, pass, fault_type; set pidx=0, t=0.
  - Next edge: enter SHIFT with se=1 and si=pattern(0,0).
- SHIFT:
  - Lasts exactly 2*CHAIN_LEN cycles with se=1; t counts 0..2*CHAIN_LEN-1.
  - si for shift t is pattern(pidx, t). P0: bit=1. P1: bit=0. P2: bit = (t mod 4) >= 2, i.e. 0,0,1,1,...
  - Compare window t >= CHAIN_LEN: on that edge, so is compared against exp = pattern(pidx, t-CHAIN_LEN).
  - On mismatch: fail_mask[pidx] <= 1 and err_count increments, saturating.
  - Loading shifts (t < CHAIN_LEN) are never compared, so unknown initial chain contents are ignored.
- End of SHIFT: after t = 2*CHAIN_LEN-1, se=0 and si=0.
  - If pidx < 2: go to GAP.
  - Else: go to DONE.
- GAP: se=0, si=0 for exactly GAP_CYCLES cycles. Then pidx++, t=0, go to SHIFT.
- DONE: lasts one cycle.
  - done=1; pass and fault_type update in that same cycle; busy=1.
  - Next state is IDLE with busy=0. Results hold until the next start.
- Latency: start accepted at edge N; first se=1 at edge N+1; done at N + 1 + 3*2*CHAIN_LEN + 2*GAP_CYCLES.
  - Example: CHAIN_LEN=8, GAP_CYCLES=2 gives done at N+53.
- start while busy is ignored, with no effect on counters.
- abort while busy: next edge IDLE, se=0, si=0, busy=0, no done pulse, pass=0. Partial fail_mask/err_count are retained for debug.
- start and abort in the same IDLE cycle: abort wins; stay IDLE.

Test Plan:
- Golden chain (CHAIN_LEN=8, bench shift-register model), pulse start -> done exactly 53 cycles after acceptance, pass=1, fail_mask=000, err_count=0, fault_type=00; se high for exactly 48 cycles.
- Chain flop 3 stuck-at-0 -> P0 fails 8 times; P1 passes; P2 (half 1s) fails 4 -> fail_mask=101, err_count=12, fault_type=01, pass=0.
- Chain flop 5 stuck-at-1 -> fail_mask=110, err_count=12, fault_type=10.
- so forced to follow si with 7-cycle latency (short chain) -> P2 mismatches, fail_mask=100, fault_type=11; also check err_count saturation with a narrowed CNT_W.
- abort pulsed at SHIFT t=5 of P1 -> next cycle se=0, busy=0, no done; a new start then completes normally with correct results.
- rst asserted mid-GAP -> all outputs at reset values next edge; start during busy and start+abort in IDLE both ignored (busy stays 0 for the latter).

Source files
------------

// File: rtl/scan_chain_test_ctrl.sv
// Flush-test sequencer for a single serial scan chain.
// Shifts three flush patterns (all-ones, all-zeros, 0011...) through the chain,
// compares scan-out against the bit shifted in CHAIN_LEN shifts earlier, and
// reports per-pattern fail flags, a saturating mismatch count and a fault class.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start; results of the last run held
// S_LOAD  | start accepted, results cleared; se rises on the next edge
// S_SHIFT | se=1, shift t = 0..2*CHAIN_LEN-1 of pattern pidx
// S_GAP   | se=0 for GAP_CYCLES cycles between patterns
// S_DONE  | one-cycle done pulse; pass and fault_type valid
module scan_chain_test_ctrl #(
  parameter int CHAIN_LEN  = 8,
  parameter int GAP_CYCLES = 2,
  parameter int CNT_W      = $clog2(3*CHAIN_LEN+1)
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             so,
  output logic             se,
  output logic             si,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       fail_mask,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       fault_type
);

  localparam int T_W = $clog2(2*CHAIN_LEN);
  localparam int G_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [T_W-1:0] T_LEN   = T_W'(CHAIN_LEN);
  localparam logic [T_W-1:0] T_LAST  = T_W'(2*CHAIN_LEN-1);
  localparam logic [G_W-1:0] GAP_LDV = G_W'(GAP_CYCLES-1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_DONE
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_pidx, w_pidx_nxt;
  logic [T_W-1:0]   r_t, w_t_nxt;
  logic [G_W-1:0]   r_gap, w_gap_nxt;
  logic             r_se, w_se_nxt;
  logic             r_si, w_si_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             r_pass, w_pass_nxt;
  logic [2:0]       r_mask, w_mask_nxt;
  logic [CNT_W-1:0] r_err, w_err_nxt;
  logic [1:0]       r_ftype, w_ftype_nxt;

  logic             w_exp_bit;
  logic             w_mismatch;
  logic [2:0]       w_mask_upd;
  logic [CNT_W-1:0] w_err_upd;

  // Flush pattern bit for shift index t: P0 ones, P1 zeros, P2 0011 repeating.
  function automatic logic f_pat(input logic [1:0] p, input logic [T_W-1:0] t);
    case (p)
      2'd0:    return 1'b1;
      2'd1:    return 1'b0;
      default: return t[1];
    endcase
  endfunction

  // Fault class from the final fail mask; P2 alone or mixed P0/P1 is "other".
  function automatic logic [1:0] f_ftype(input logic [2:0] m);
    case (m)
      3'b000:          return 2'b00;
      3'b001, 3'b101:  return 2'b01;
      3'b010, 3'b110:  return 2'b10;
      default:         return 2'b11;
    endcase
  endfunction

  assign se         = r_se;
  assign si         = r_si;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_mask  = r_mask;
  assign err_count  = r_err;
  assign fault_type = r_ftype;

  // Compare path: wrap-around of r_t - T_LEN is harmless, only bit 1 matters for P2.
  always_comb begin
    w_exp_bit  = f_pat(r_pidx, r_t - T_LEN);
    w_mismatch = (r_state == S_SHIFT) && (r_t >= T_LEN) && (so != w_exp_bit);
    w_mask_upd = r_mask | (w_mismatch ? (3'b001 << r_pidx) : 3'b000);
    w_err_upd  = (w_mismatch && (r_err != '1)) ? r_err + CNT_W'(1) : r_err;
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_pidx_nxt  = r_pidx;
    w_t_nxt     = r_t;
    w_gap_nxt   = r_gap;
    w_se_nxt    = r_se;
    w_si_nxt    = r_si;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_pass_nxt  = r_pass;
    w_mask_nxt  = r_mask;
    w_err_nxt   = r_err;
    w_ftype_nxt = r_ftype;

    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_LOAD;
          w_busy_nxt  = 1'b1;
          w_mask_nxt  = 3'b000;
          w_err_nxt   = '0;
          w_pass_nxt  = 1'b0;
          w_ftype_nxt = 2'b00;
          w_pidx_nxt  = 2'd0;
          w_t_nxt     = '0;
        end
      end
      S_LOAD: begin
        w_state_nxt = S_SHIFT;
        w_se_nxt    = 1'b1;
        w_si_nxt    = f_pat(2'd0, '0);
      end
      S_SHIFT: begin
        w_mask_nxt = w_mask_upd;
        w_err_nxt  = w_err_upd;
        if (r_t == T_LAST) begin
          w_se_nxt = 1'b0;
          w_si_nxt = 1'b0;
          if (r_pidx == 2'd2) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_mask_upd == 3'b000);
            w_ftype_nxt = f_ftype(w_mask_upd);
          end else begin
            w_state_nxt = S_GAP;
            w_gap_nxt   = GAP_LDV;
          end
        end else begin
          w_t_nxt  = r_t + T_W'(1);
          w_si_nxt = f_pat(r_pidx, r_t + T_W'(1));
        end
      end
      S_GAP: begin
        if (r_gap == '0) begin
          w_state_nxt = S_SHIFT;
          w_pidx_nxt  = r_pidx + 2'd1;
          w_t_nxt     = '0;
          w_se_nxt    = 1'b1;
          w_si_nxt    = f_pat(r_pidx + 2'd1, '0);
        end else begin
          w_gap_nxt = r_gap - G_W'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_se_nxt    = 1'b0;
        w_si_nxt    = 1'b0;
      end
    endcase

    // Abort drops the run; partial mask/count stay visible, the abort-edge compare is discarded.
    if (abort && (r_state != S_IDLE)) begin
      w_state_nxt = S_IDLE;
      w_se_nxt    = 1'b0;
      w_si_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
      w_done_nxt  = 1'b0;
      w_pass_nxt  = 1'b0;
      w_mask_nxt  = r_mask;
      w_err_nxt   = r_err;
      w_ftype_nxt = r_ftype;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge sclk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pidx  <= 2'd0;
      r_t     <= '0;
      r_gap   <= '0;
      r_se    <= 1'b0;
      r_si    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_mask  <= 3'b000;
      r_err   <= '0;
      r_ftype <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_pidx  <= w_pidx_nxt;
      r_t     <= w_t_nxt;
      r_gap   <= w_gap_nxt;
      r_se    <= w_se_nxt;
      r_si    <= w_si_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_pass  <= w_pass_nxt;
      r_mask  <= w_mask_nxt;
      r_err   <= w_err_nxt;
      r_ftype <= w_ftype_nxt;
    end
  end

endmodule

// File: tb/tb_scan_chain_test_ctrl.sv
// Directed bench: two controllers (default count width and a 2-bit count)
// each drive an 8-flop chain model with selectable fault injection.
module tb_scan_chain_test_ctrl;

  logic sclk = 1'b0;
  logic rst, start, abort;

  logic       so_a, se_a, si_a, busy_a, done_a, pass_a;
  logic [2:0] mask_a;
  logic [4:0] err_a;
  logic [1:0] ft_a;

  logic       so_b, se_b, si_b, busy_b, done_b, pass_b;
  logic [2:0] mask_b;
  logic [1:0] err_b;
  logic [1:0] ft_b;

  // 0 golden, 1 flop3 stuck-at-0, 2 flop5 stuck-at-1, 3 so taps flop 6 (7-shift latency)
  int mode = 0;
  int n_vec = 0;
  int n_mis = 0;

  logic [7:0] ch_a = 8'h5A;
  logic [7:0] ch_b = 8'hC3;
  logic [7:0] wq_a, wq_b;

  // Clock generation.
  always #5 sclk = ~sclk;

  scan_chain_test_ctrl #(.CHAIN_LEN(8), .GAP_CYCLES(2)) u_dut_a (
    .sclk(sclk), .rst(rst), .start(start), .abort(abort), .so(so_a),
    .se(se_a), .si(si_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .fail_mask(mask_a), .err_count(err_a), .fault_type(ft_a)
  );

  scan_chain_test_ctrl #(.CHAIN_LEN(8), .GAP_CYCLES(2), .CNT_W(2)) u_dut_b (
    .sclk(sclk), .rst(rst), .start(start), .abort(abort), .so(so_b),
    .se(se_b), .si(si_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_mask(mask_b), .err_count(err_b), .fault_type(ft_b)
  );

  // Faulted view of each chain's flop outputs.
  always_comb begin
    wq_a = ch_a;
    wq_b = ch_b;
    if (mode == 1) begin wq_a[3] = 1'b0; wq_b[3] = 1'b0; end
    if (mode == 2) begin wq_a[5] = 1'b1; wq_b[5] = 1'b1; end
  end

  assign so_a = (mode == 3) ? wq_a[6] : wq_a[7];
  assign so_b = (mode == 3) ? wq_b[6] : wq_b[7];

  // Chain models shift only while scan enable is high.
  always @(posedge sclk) begin
    if (se_a) ch_a <= {wq_a[6:0], si_a};
    if (se_b) ch_b <= {wq_b[6:0], si_b};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  // Start a run, optionally re-pulse start at cycle mid, wait for done (bounded).
  task automatic run(input int mid, output int lat, output int se_cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy_a, 1);
    lat = 0;
    se_cnt = 0;
    while (!done_a && lat < 200) begin
      start = (lat == mid);
      tick();
      start = 1'b0;
      lat++;
      if (se_a) se_cnt++;
    end
  endtask

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  // Directed sequence.
  initial begin
    int lat, sec, dcnt;
    rst = 1'b1; start = 1'b1; abort = 1'b0; mode = 0;
    repeat (3) tick();
    rst = 1'b0; start = 1'b0;
    chk("rst_se", se_a, 0);
    chk("rst_si", si_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_pass", pass_a, 0);
    chk("rst_mask", mask_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_ft", ft_a, 0);

    // golden chain
    run(-1, lat, sec);
    chk("gold_lat", lat, 53);
    chk("gold_se_cycles", sec, 48);
    chk("gold_pass", pass_a, 1);
    chk("gold_mask", mask_a, 0);
    chk("gold_err", err_a, 0);
    chk("gold_ft", ft_a, 0);
    chk("gold_err_b", err_b, 0);
    tick();
    chk("gold_done_drop", done_a, 0);
    chk("gold_busy_drop", busy_a, 0);
    chk("gold_pass_hold", pass_a, 1);

    // flop 3 stuck-at-0
    mode = 1;
    run(-1, lat, sec);
    chk("sa0_lat", lat, 53);
    chk("sa0_mask", mask_a, 3'b101);
    chk("sa0_err", err_a, 12);
    chk("sa0_ft", ft_a, 2'b01);
    chk("sa0_pass", pass_a, 0);
    chk("sa0_err_sat", err_b, 3);
    tick();

    // flop 5 stuck-at-1, with a start pulse while busy
    mode = 2;
    run(10, lat, sec);
    chk("sa1_lat", lat, 53);
    chk("sa1_mask", mask_a, 3'b110);
    chk("sa1_err", err_a, 12);
    chk("sa1_ft", ft_a, 2'b10);
    chk("sa1_pass", pass_a, 0);
    tick();

    // effective 7-flop chain
    mode = 3;
    run(-1, lat, sec);
    chk("short_mask", mask_a, 3'b100);
    chk("short_err", err_a, 4);
    chk("short_ft", ft_a, 2'b11);
    chk("short_err_sat", err_b, 3);
    tick();

    // abort at P1 shift t=5 (edge N+24)
    mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (24) tick();
    chk("abt_pre_se", se_a, 1);
    chk("abt_pre_si", si_a, 0);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abt_se", se_a, 0);
    chk("abt_busy", busy_a, 0);
    chk("abt_done", done_a, 0);
    chk("abt_pass", pass_a, 0);
    chk("abt_mask_kept", mask_a, 3'b001);
    chk("abt_err_kept", err_a, 8);
    dcnt = 0;
    repeat (60) begin
      tick();
      if (done_a || se_a) dcnt++;
    end
    chk("abt_quiet", dcnt, 0);

    // normal run after abort
    mode = 0;
    run(-1, lat, sec);
    chk("post_abt_lat", lat, 53);
    chk("post_abt_pass", pass_a, 1);
    chk("post_abt_mask", mask_a, 0);
    chk("post_abt_err", err_a, 0);
    tick();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("sa_idle_busy", busy_a, 0);
    chk("sa_idle_se", se_a, 0);
    tick();
    chk("sa_idle_busy2", busy_a, 0);
    chk("sa_idle_pass_hold", pass_a, 1);

    // reset in the first gap of a stuck-at-0 run
    mode = 1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (17) tick();
    chk("gap_se", se_a, 0);
    chk("gap_busy", busy_a, 1);
    chk("gap_mask", mask_a, 3'b001);
    chk("gap_err", err_a, 8);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("grst_se", se_a, 0);
    chk("grst_si", si_a, 0);
    chk("grst_busy", busy_a, 0);
    chk("grst_done", done_a, 0);
    chk("grst_pass", pass_a, 0);
    chk("grst_mask", mask_a, 0);
    chk("grst_err", err_a, 0);
    chk("grst_ft", ft_a, 0);
    tick();
    chk("grst_idle", busy_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
